// File: rtl/io_input_pkg.sv
// io_input_pkg: register map, input counts and bus byte-swap helper for the switch/button peripheral
package io_input_pkg;

    localparam logic [15:0] IO_SW_ADDR  = 16'hf300;
    localparam logic [15:0] IO_BTN_ADDR = 16'hf304;
    localparam logic [15:0] IO_EVT_ADDR = 16'hf308;
    localparam logic [31:0] ZERO_WORD   = 32'h0;
    localparam logic        RST_ENABLE  = 1'b0;
    localparam logic        CHIP_ENABLE = 1'b1;

    localparam int NUM_SW  = 16;
    localparam int NUM_BTN = 5;
    localparam int NUM_IN  = NUM_SW + NUM_BTN;

    typedef logic [NUM_SW-1:0]  sw_vec_t;
    typedef logic [NUM_BTN-1:0] btn_vec_t;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/io_input_debounce_bit.sv
// debounce_bit: two-flop synchroniser followed by a consecutive-cycle debounce counter
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable
);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_stable)
                r_cnt <= '0;
            else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/io_input.sv
// io_input: debounced switch/button read port with latched, write-1-to-clear button press events
module io_input
    import io_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic        btn_irq
);

    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] w_stable;
    sw_vec_t           w_sw;
    btn_vec_t          w_btn;
    btn_vec_t          w_rise;
    btn_vec_t          w_clr;
    logic [31:0]       w_data_i;
    logic [31:0]       w_rd;
    logic              w_unused;
    btn_vec_t          r_stable_d;
    btn_vec_t          r_press_evt;

    assign w_raw = {btn, sw};

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_db
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_raw   (w_raw[g]),
                .o_stable(w_stable[g])
            );
        end
    endgenerate

    assign w_sw     = w_stable[NUM_SW-1:0];
    assign w_btn    = w_stable[NUM_IN-1:NUM_SW];
    assign w_rise   = w_btn & ~r_stable_d;
    assign w_data_i = bswap(din);
    assign w_clr    = (ce == CHIP_ENABLE && we && addr[15:0] == IO_EVT_ADDR) ? w_data_i[NUM_BTN-1:0] : '0;
    assign w_unused = &{1'b0, addr[31:16], w_data_i[31:NUM_BTN]};

    // a rise in the same cycle as a clear wins, so no press is ever lost
    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE) begin
            r_stable_d  <= '0;
            r_press_evt <= '0;
        end else begin
            r_stable_d  <= w_btn;
            r_press_evt <= (r_press_evt & ~w_clr) | w_rise;
        end
    end

    always_comb begin
        w_rd = (addr[15:0] == IO_SW_ADDR)  ? {16'b0, w_sw} :
               (addr[15:0] == IO_BTN_ADDR) ? {27'b0, w_btn} :
               (addr[15:0] == IO_EVT_ADDR) ? {27'b0, r_press_evt} : ZERO_WORD;
        dout = (rst_n == RST_ENABLE) ? ZERO_WORD : bswap(w_rd);
    end

    assign btn_irq = |r_press_evt;

endmodule

// File: tb/tb_io_input.sv
// tb_io_input: directed self-checking bench for io_input with DEBOUNCE_CYCLES=8
module tb_io_input;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic        btn_irq;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] A_SW  = 32'h0000f300;
    localparam logic [31:0] A_BTN = 32'h0000f304;
    localparam logic [31:0] A_EVT = 32'h0000f308;

    io_input #(.DEBOUNCE_CYCLES(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .addr   (addr),
        .we     (we),
        .din    (din),
        .dout   (dout),
        .sw     (sw),
        .btn    (btn),
        .btn_irq(btn_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce   = 1'b1;
        we   = 1'b1;
        addr = a;
        din  = d;
        tick(1);
        ce = 1'b0;
        we = 1'b0;
        din = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        din   = 32'h0;
        sw    = 16'h0;
        btn   = 5'h0;
        tick(3);
        rd("rst_hold_sw", A_SW, 32'h0);
        rst_n = 1'b1;
        rd("rst_sw", A_SW, 32'h0);
        rd("rst_btn", A_BTN, 32'h0);
        rd("rst_evt", A_EVT, 32'h0);
        chk("rst_irq", {31'b0, btn_irq}, 32'h0);

        sw = 16'h00A5;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            rd("sw_latency_low", A_SW, 32'h0);
        end
        tick(1);
        rd("sw_latency_high", A_SW, 32'hA5000000);

        btn = 5'b00001;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            rd("glitch_btn_hi", A_BTN, 32'h0);
        end
        btn = 5'b00000;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            rd("glitch_btn_lo", A_BTN, 32'h0);
            rd("glitch_evt", A_EVT, 32'h0);
            chk("glitch_irq", {31'b0, btn_irq}, 32'h0);
        end

        btn = 5'b00100;
        tick(20);
        rd("press_btn", A_BTN, 32'h04000000);
        rd("press_evt", A_EVT, 32'h04000000);
        chk("press_irq", {31'b0, btn_irq}, 32'h1);
        wr(A_EVT, 32'h04000000);
        rd("w1c_evt", A_EVT, 32'h0);
        chk("w1c_irq", {31'b0, btn_irq}, 32'h0);
        btn = 5'b00000;
        tick(15);
        rd("release_btn", A_BTN, 32'h0);
        rd("release_evt", A_EVT, 32'h0);
        chk("release_irq", {31'b0, btn_irq}, 32'h0);

        btn = 5'b00010;
        tick(10);
        rd("coll_btn", A_BTN, 32'h02000000);
        rd("coll_evt_pre", A_EVT, 32'h0);
        wr(A_EVT, 32'h02000000);
        rd("coll_evt", A_EVT, 32'h02000000);
        chk("coll_irq", {31'b0, btn_irq}, 32'h1);
        wr(A_EVT, 32'h02000000);
        rd("coll_clear", A_EVT, 32'h0);
        btn = 5'b00000;
        tick(15);

        rd("unmapped_rd", 32'h0000f30c, 32'h0);
        rd("upper_addr_sw", 32'h1234f300, 32'hA5000000);
        wr(A_SW, 32'hffffffff);
        wr(A_BTN, 32'hffffffff);
        rd("wr_sw_ignored", A_SW, 32'hA5000000);
        rd("wr_btn_ignored", A_BTN, 32'h0);
        rd("wr_evt_unchanged", A_EVT, 32'h0);

        btn = 5'b01000;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        rd("midrst_btn", A_BTN, 32'h0);
        chk("midrst_irq", {31'b0, btn_irq}, 32'h0);
        for (int i = 0; i < 9; i++) begin
            tick(1);
            rd("midrst_btn_low", A_BTN, 32'h0);
        end
        tick(1);
        rd("midrst_btn_high", A_BTN, 32'h08000000);
        rd("midrst_sw_back", A_SW, 32'hA5000000);
        rd("midrst_evt_pre", A_EVT, 32'h0);
        tick(1);
        rd("midrst_evt", A_EVT, 32'h08000000);
        chk("midrst_evt_irq", {31'b0, btn_irq}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
